// File: rtl/aes_pkg.sv
// AES-128 shared types, round constants and word helpers.
// Used by the AddRoundKey stage and the S-box.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int BLOCK_W    = 128;
  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;

  typedef logic [BYTE_W-1:0]  byte_t;
  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic {
    NO_KEY,
    RUN
  } state_t;

  // RCON[1] is the lowest element of the packed array.
  localparam logic [10:1][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
    8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  function automatic byte_t rcon(logic [3:0] r);
    byte_t c;
    c = 8'h00;
    for (int i = 1; i <= 10; i++)
      if (r == i[3:0]) c = RCON[i];
    return c;
  endfunction

  // word w = bits[127-32w -: 32]
  function automatic word_t get_word(block_t b, int w);
    return b[BLOCK_W-1-WORD_W*w -: WORD_W];
  endfunction

  function automatic word_t rot_word(word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_add_round_key_stage_if.sv
// Valid/ready bundle around the AddRoundKey stage.
// slave = the stage, master = upstream/downstream side.
interface aes_add_round_key_stage_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  block_t     in_data;
  logic       out_valid;
  logic       out_ready;
  block_t     out_data;
  logic [3:0] out_round;
  logic       out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_round, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_round, out_last
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
// GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t data,
  output byte_t sub
);

  function automatic byte_t xtime(byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(byte_t a, byte_t b);
    byte_t p;
    byte_t x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic byte_t sbox_f(byte_t x);
    byte_t sq;
    byte_t inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  endfunction

  assign sub = sbox_f(data);

endmodule

// File: rtl/aes_add_round_key_stage.sv
// AES-128 AddRoundKey stage with on-the-fly key expansion.
// One round key per accepted block; wraps to the cipher key after round 10.
module aes_add_round_key_stage
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   key_load,
  input  block_t key_in,
  output logic   key_ready,
  aes_add_round_key_stage_if.slave bus
);

  generate
    if (NUM_ROUNDS != 10) begin : g_bad_rounds
      $error("aes_add_round_key_stage: only NUM_ROUNDS=10 supported");
    end
  endgenerate

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  state_t     state;
  block_t     cipher_key;
  block_t     rk;
  logic [3:0] rnd;
  logic       out_valid;
  block_t     out_data;
  logic [3:0] out_round;
  logic       out_last;

  logic       accept;
  logic [3:0] rnd_nxt;
  word_t      w0, w1, w2, w3;
  word_t      rw, sw, t;
  word_t      n0, n1, n2, n3;
  block_t     rk_nxt;

  assign key_ready     = (state == RUN);
  assign bus.in_ready  = key_ready & ~key_load
                       & (~out_valid | bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_round = out_round;
  assign bus.out_last  = out_last;

  assign rnd_nxt = rnd + 4'd1;
  assign w0 = get_word(rk, 0);
  assign w1 = get_word(rk, 1);
  assign w2 = get_word(rk, 2);
  assign w3 = get_word(rk, 3);
  assign rw = rot_word(w3);

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (
      .data (rw[31-8*g -: 8]),
      .sub  (sw[31-8*g -: 8])
    );
  end

  assign t  = sw ^ {rcon(rnd_nxt), 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rk_nxt = {n0, n1, n2, n3};

  // Key/round sequencing and the registered output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NO_KEY;
      cipher_key <= '0;
      rk         <= '0;
      rnd        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_round  <= '0;
      out_last   <= 1'b0;
    end else if (key_load) begin
      state      <= RUN;
      cipher_key <= key_in;
      rk         <= key_in;
      rnd        <= '0;
      out_valid  <= 1'b0;
    end else begin
      unique case (state)
        NO_KEY: ;
        RUN: begin
          if (accept) begin
            out_data  <= bus.in_data ^ rk;
            out_round <= rnd;
            out_last  <= (rnd == LAST);
            out_valid <= 1'b1;
            if (rnd == LAST) begin
              rk  <= cipher_key;
              rnd <= '0;
            end else begin
              rk  <= rk_nxt;
              rnd <= rnd_nxt;
            end
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_add_round_key_stage.sv
// Bench for aes_add_round_key_stage: FIPS-197 vectors,
// corner sequences and a randomized scoreboard run.
module tb_aes_add_round_key_stage;

  logic         clk;
  logic         clk_en;
  logic         rst_n;
  logic         key_load;
  logic [127:0] key_in;
  logic         key_ready;

  aes_add_round_key_stage_if bus();

  aes_add_round_key_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .key_ready (key_ready),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  int n_cmp;
  int n_bad;

  logic [7:0]   sb [256];
  logic [127:0] m_keys [11];
  logic         m_kr;
  logic         m_ov;
  logic [127:0] m_od;
  logic [3:0]   m_or;
  logic         m_ol;
  int           m_r;

  localparam logic [127:0] K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P = 128'h3243f6a8885a308d313198a2e0370734;

  logic [127:0] rkc [11];

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
    logic [3:0]   rnd;
  } vec_t;
  vec_t vt [22];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
      sb[p] = x;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic m_reset();
    m_kr = 0; m_ov = 0; m_od = '0; m_or = '0; m_ol = 0; m_r = 0;
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic cycle(input logic kl, input logic [127:0] kin,
                       input logic iv, input logic [127:0] id,
                       input logic ordy);
    logic exp_ir;
    key_load = kl;
    key_in = kin;
    bus.in_valid = iv;
    bus.in_data = id;
    bus.out_ready = ordy;
    #1;
    exp_ir = m_kr & ~kl & (~m_ov | ordy);
    chk("in_ready", {127'd0, bus.in_ready}, {127'd0, exp_ir});
    if (kl) begin
      m_kr = 1; expand(kin); m_r = 0; m_ov = 0;
    end else if (iv && exp_ir) begin
      m_od = id ^ m_keys[m_r];
      m_or = 4'(m_r);
      m_ol = (m_r == 10);
      m_ov = 1;
      m_r = (m_r == 10) ? 0 : m_r + 1;
    end else if (ordy) begin
      m_ov = 0;
    end
    @(posedge clk);
    #1;
    chk("key_ready", {127'd0, key_ready}, {127'd0, m_kr});
    chk("out_valid", {127'd0, bus.out_valid}, {127'd0, m_ov});
    chk("out_data", bus.out_data, m_od);
    chk("out_round", {124'd0, bus.out_round}, {124'd0, m_or});
    chk("out_last", {127'd0, bus.out_last}, {127'd0, m_ol});
    @(negedge clk);
  endtask

  logic [127:0] held;
  logic [127:0] d4;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clk_en = 1;
    rst_n = 0;
    key_load = 0;
    key_in = '0;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.out_ready = 0;
    build_sbox();
    m_reset();

    rkc[0]  = K;
    rkc[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rkc[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rkc[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rkc[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rkc[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rkc[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rkc[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rkc[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rkc[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rkc[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int j = 0; j < 22; j++) begin
      vt[j].din = (j == 0) ? P : '0;
      vt[j].exp = vt[j].din ^ rkc[j % 11];
      vt[j].rnd = 4'(j % 11);
    end

    repeat (3) @(negedge clk);
    chk("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("rst_out_data", bus.out_data, 128'd0);
    chk("rst_key_ready", {127'd0, key_ready}, 128'd0);
    rst_n = 1;
    @(negedge clk);

    // in_valid with no key loaded is ignored
    repeat (3) cycle(0, '0, 1, P, 1);

    // key_load with in_valid in the same cycle: not accepted
    cycle(1, K, 1, P, 1);

    // FIPS-197 vectors, two back-to-back blocks
    for (int i = 0; i < 22; i++) begin
      cycle(0, '0, 1, vt[i].din, 1);
      chk("tbl_data", bus.out_data, vt[i].exp);
      chk("tbl_round", {124'd0, bus.out_round}, {124'd0, vt[i].rnd});
      chk("tbl_last", {127'd0, bus.out_last},
          {127'd0, (vt[i].rnd == 4'd10)});
    end

    // Stall after the round-3 accept
    cycle(1, K, 0, '0, 1);
    for (int r = 0; r < 4; r++)
      cycle(0, '0, 1, {$urandom, $urandom, $urandom, $urandom}, 1);
    held = bus.out_data;
    for (int s = 0; s < 5; s++) begin
      cycle(0, '0, 1, {$urandom, $urandom, $urandom, $urandom}, 0);
      chk("hold_data", bus.out_data, held);
      chk("hold_round", {124'd0, bus.out_round}, 128'd3);
    end
    d4 = {$urandom, $urandom, $urandom, $urandom};
    cycle(0, '0, 1, d4, 1);
    chk("round4_data", bus.out_data, d4 ^ rkc[4]);

    // key_load while round 6 is pending
    cycle(0, '0, 1, '0, 1);
    cycle(0, '0, 1, '0, 1);
    chk("pre_kl_round", {124'd0, bus.out_round}, 128'd6);
    cycle(1, K2, 1, '0, 0);
    chk("kl_flush", {127'd0, bus.out_valid}, 128'd0);
    cycle(0, '0, 1, '0, 1);
    chk("newkey_round", {124'd0, bus.out_round}, 128'd0);
    chk("newkey_data", bus.out_data, K2);

    // Randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      cycle(($urandom_range(0, 49) == 0),
            {$urandom, $urandom, $urandom, $urandom},
            ($urandom_range(0, 3) != 0),
            {$urandom, $urandom, $urandom, $urandom},
            ($urandom_range(0, 3) != 0));
    end

    // Async reset mid-block with the clock stopped
    cycle(1, K, 0, '0, 1);
    cycle(0, '0, 1, P, 1);
    cycle(0, '0, 1, P, 0);
    clk_en = 0;
    bus.in_valid = 1;
    #2;
    rst_n = 0;
    #2;
    m_reset();
    chk("arst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("arst_out_data", bus.out_data, 128'd0);
    chk("arst_out_round", {124'd0, bus.out_round}, 128'd0);
    chk("arst_out_last", {127'd0, bus.out_last}, 128'd0);
    chk("arst_key_ready", {127'd0, key_ready}, 128'd0);
    chk("arst_in_ready", {127'd0, bus.in_ready}, 128'd0);
    #10;
    rst_n = 1;
    clk_en = 1;
    @(negedge clk);
    repeat (3) cycle(0, '0, 1, P, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_add_round_key_stage.md
Name: aes_add_round_key_stage

Overview:
- AES-128 AddRoundKey stage with on-the-fly key expansion.
- Sits directly downstream of the MixColumns stage. In round 10 it takes the ShiftRows output instead; in round 0 it takes the plaintext.
- Each accepted 128-bit state is XORed with the current round key and registered. The key schedule then advances one round key per accepted transfer.
- Valid/ready on both sides, so it can sit in an iterative round loop or a stall-able pipeline.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds. Only 10 (AES-128) is supported; elaboration error otherwise.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- key_load  input  1  one-cycle pulse: capture key_in, restart at round 0
- key_in  input  128  cipher key; bits[127:120] = key byte 0
- key_ready  output  1  a key has been loaded since reset
- in_valid  input  1  in_data valid
- in_ready  output  1  stage can accept in_data this cycle
- in_data  input  128  state (plaintext / MixColumns output / ShiftRows output); byte j = bits[127-8j -: 8], column-major
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  128  in_data XOR round key
- out_round  output  4  round index (0..10) of out_data
- out_last  output  1  out_round == 10

Behaviour:
- Reset (async assert, sync release):
  - key_ready=0, out_valid=0, out_data=0, out_round=0, out_last=0.
  - Round counter rnd=0; key registers cleared.
- FSM states:
  - NO_KEY: reset state; in_ready=0.
  - RUN: entered on key_load; stays in RUN until reset.
- key_load, in any state:
  - next cycle: cipher_key<=key_in, rk<=key_in, rnd<=0, key_ready<=1.
  - out_valid<=0: a pending result is flushed and lost.
  - Has priority over everything else.
- in_ready = key_ready & ~key_load & (~out_valid | out_ready). This is a single-register skid-free stage with full throughput.
- Accept when in_valid & in_ready. Next cycle:
  - out_data<=in_data^rk; out_round<=rnd; out_last<=(rnd==10); out_valid<=1.
  - If rnd<10: rk<=next_rk(rk, RCON[rnd+1]) and rnd<=rnd+1.
  - If rnd==10: rk<=cipher_key and rnd<=0, so the next block starts without a reload.
- Latency: 1 cycle from accept to out_valid.
- Output hold: out_data, out_round and out_last stay stable while out_valid & ~out_ready.
- Output clear: out_valid drops after out_ready only if no new accept happens in the same cycle.
- next_rk, with words w0..w3, w0=bits[127:96]:
  - t = SubWord(RotWord(w3)) ^ {rcon,8'h00,8'h00,8'h00}
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'
  - RotWord({a,b,c,d}) = {b,c,d,a}.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- No round-in port: the sequencing is implicit. The upstream controller must present the 11 states of a block in order. out_round tells downstream whether to skip MixColumns.
- key_load in the same cycle as in_valid: the input is not accepted (in_ready=0), and the upstream must retry.
- in_valid while NO_KEY: ignored; no output is produced.
- Reset mid-block: all state is lost; a key_load is required again.

Decomposition:
- aes_pkg holds:
  - NUM_ROUNDS
  - the RCON array (index 1..10)
  - byte/word slicing constants (word w = bits[127-32w -: 32])
  - the RotWord function
- One sub-module: aes_sbox, a combinational 8-bit forward S-box. It is instantiated 4x for SubWord and is reusable by the SubBytes stage.
- The key schedule stays inline; it is small enough.

Test Plan:
1. Reset, then key_load with key_in=2b7e151628aed2a6abf7158809cf4f3c, in_valid=1, in_data=3243f6a8885a308d313198a2e0370734 -> key_ready=1 after 1 cycle; first out_data=193de3bea0f4e22b9ac68d2ae9f84808, out_round=0.
2. Same key, 11 transfers of in_data=0 with out_ready=1 ->
   - out_data in round 1 = a0fafe1788542cb123a339392a6c7605;
   - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with out_last=1;
   - one result per cycle.
3. Back-to-back blocks, 22 transfers of in_data=0 -> transfer 12 outputs 2b7e151628aed2a6abf7158809cf4f3c, out_round=0 (automatic key reload).
4. Hold out_ready=0 for 5 cycles after the round-3 accept -> out_data/out_round stable, in_ready=0, rk not advanced. Release -> round 4 equals the FIPS-197 round-4 key XOR in_data.
5. key_load asserted while out_valid=1 at round 6 -> out_valid=0 next cycle; the next accept yields out_round=0 using the new key.
6. in_valid=1 before any key_load, and async reset asserted mid-block with clk stopped -> in_ready=0 and no out_valid; on reset, outputs go to 0 immediately without a clock edge.
